// File: rtl/sc_preamble_inserter_if.sv
// IQ sample stream channel (tdata/tlast/tvalid/tready) used on both sides of the preamble inserter.
interface sc_preamble_inserter_if;
   logic [31:0] tdata;
   logic        tlast;
   logic        tvalid;
   logic        tready;

   modport master (output tdata, output tlast, output tvalid, input tready);
   modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/sc_preamble_inserter.sv
// Schmidl-Cox TX framer: prepends a cyclic prefix plus repeated training symbols from a
// settings-loaded RAM to each IQ packet, then optionally emits a zero-valued guard-gap packet.
module sc_preamble_inserter #(
   parameter int         WINDOW_LEN       = 64,
   parameter int         CP_LEN           = 32,
   parameter int         NUM_SYMBOLS      = 2,
   parameter logic [7:0] SR_GAP_LEN       = 8'd8,
   parameter logic [7:0] SR_PREAMBLE_ADDR = 8'd9,
   parameter logic [7:0] SR_PREAMBLE_DATA = 8'd10,
   parameter logic [7:0] SR_ENABLE        = 8'd11
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic                   set_stb,
   input  logic [7:0]             set_addr,
   input  logic [31:0]            set_data,
   sc_preamble_inserter_if.slave  i_axis,
   sc_preamble_inserter_if.master o_axis
);

   localparam int            AW       = $clog2(WINDOW_LEN);
   localparam logic [AW-1:0] CP_START = AW'(WINDOW_LEN - CP_LEN);
   localparam logic [AW-1:0] CP_LAST  = AW'(CP_LEN - 1);
   localparam logic [AW-1:0] SYM_LAST = AW'(WINDOW_LEN - 1);
   localparam logic [3:0]    REP_LAST = 4'(NUM_SYMBOLS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CP,
      S_SYM,
      S_PAYLOAD,
      S_GAP,
      S_BYPASS
   } state_t;

   state_t        state, state_n;
   logic [AW-1:0] cnt, cnt_n;
   logic [3:0]    rep, rep_n;
   logic [15:0]   gap_cnt, gap_cnt_n;
   logic [15:0]   gap_len, gap_len_q;
   logic          gap_ld;
   logic          enable;
   logic [AW-1:0] wptr;

   logic [31:0]   ram [WINDOW_LEN];
   logic [31:0]   ram_q;
   logic [AW-1:0] rd_ptr, rd_addr;
   logic          rd_en;

   logic          o_valid_q, o_last_q;
   logic [31:0]   o_data_q;
   logic          out_ready, out_valid_n, out_last_n;
   logic [31:0]   out_data_n;
   logic          in_xfer;

   assign out_ready     = ~o_valid_q | o_axis.tready;
   assign i_axis.tready = ((state == S_PAYLOAD) || (state == S_BYPASS)) && out_ready;
   assign in_xfer       = i_axis.tvalid & i_axis.tready;

   assign o_axis.tvalid = o_valid_q;
   assign o_axis.tdata  = o_data_q;
   assign o_axis.tlast  = o_last_q;

   // RAM pointer and contents only move while idle so a frame in flight is never corrupted.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         gap_len <= 16'd0;
         enable  <= 1'b0;
         wptr    <= '0;
      end else if (set_stb) begin
         case (set_addr)
            SR_GAP_LEN:       gap_len <= set_data[15:0];
            SR_ENABLE:        enable  <= set_data[0];
            SR_PREAMBLE_ADDR: if (state == S_IDLE) wptr <= set_data[AW-1:0];
            SR_PREAMBLE_DATA: if (state == S_IDLE) wptr <= wptr + 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (set_stb && (set_addr == SR_PREAMBLE_DATA) && (state == S_IDLE)) begin
         ram[wptr] <= set_data;
      end
      if (rd_en) begin
         ram_q <= ram[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= S_IDLE;
         cnt       <= '0;
         rep       <= 4'd0;
         gap_cnt   <= 16'd0;
         gap_len_q <= 16'd0;
         rd_ptr    <= '0;
         o_valid_q <= 1'b0;
         o_data_q  <= 32'd0;
         o_last_q  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         rep     <= rep_n;
         gap_cnt <= gap_cnt_n;
         if (gap_ld) begin
            gap_len_q <= gap_len;
         end
         if (rd_en) begin
            rd_ptr <= rd_addr;
         end
         if (out_ready) begin
            o_valid_q <= out_valid_n;
            o_data_q  <= out_data_n;
            o_last_q  <= out_last_n;
         end
      end
   end

   // ram_q always holds the next preamble sample; it only advances when that sample is taken,
   // and the CP-to-SYM boundary is just the address wrapping from WINDOW_LEN-1 to 0.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      rep_n       = rep;
      gap_cnt_n   = gap_cnt;
      gap_ld      = 1'b0;
      rd_en       = 1'b0;
      rd_addr     = rd_ptr + 1'b1;
      out_valid_n = 1'b0;
      out_data_n  = 32'd0;
      out_last_n  = 1'b0;

      case (state)
         S_IDLE: begin
            if (i_axis.tvalid) begin
               if (enable) begin
                  rd_en   = 1'b1;
                  rd_addr = CP_START;
                  cnt_n   = '0;
                  rep_n   = 4'd0;
                  state_n = (CP_LEN == 0) ? S_SYM : S_CP;
               end else begin
                  state_n = S_BYPASS;
               end
            end
         end

         S_CP: begin
            if (out_ready) begin
               out_valid_n = 1'b1;
               out_data_n  = ram_q;
               rd_en       = 1'b1;
               if (cnt == CP_LAST) begin
                  cnt_n   = '0;
                  state_n = S_SYM;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end

         S_SYM: begin
            if (out_ready) begin
               out_valid_n = 1'b1;
               out_data_n  = ram_q;
               rd_en       = 1'b1;
               if (cnt == SYM_LAST) begin
                  cnt_n = '0;
                  if (rep == REP_LAST) begin
                     rep_n   = 4'd0;
                     state_n = S_PAYLOAD;
                  end else begin
                     rep_n = rep + 1'b1;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end

         S_PAYLOAD, S_BYPASS: begin
            if (in_xfer) begin
               out_valid_n = 1'b1;
               out_data_n  = i_axis.tdata;
               out_last_n  = i_axis.tlast;
               if (i_axis.tlast) begin
                  if ((state == S_PAYLOAD) && (gap_len != 16'd0)) begin
                     gap_ld    = 1'b1;
                     gap_cnt_n = 16'd0;
                     state_n   = S_GAP;
                  end else begin
                     state_n = S_IDLE;
                  end
               end
            end
         end

         S_GAP: begin
            if (out_ready) begin
               out_valid_n = 1'b1;
               if (gap_cnt == (gap_len_q - 16'd1)) begin
                  out_last_n = 1'b1;
                  gap_cnt_n  = 16'd0;
                  state_n    = S_IDLE;
               end else begin
                  gap_cnt_n = gap_cnt + 1'b1;
               end
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

endmodule
